// File: rtl/bram_pkg.sv
// Shared types and helpers for the wide-read block memory.
package bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned MAX_RATIO        = 8;
  localparam int unsigned MAX_READ_LATENCY = 4;

  // Word address of read lane i, wrapping modulo 2**aw.
  function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                            input int unsigned i,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (base + 32'(i)) & mask;
  endfunction

endpackage

// File: rtl/bram_wide_read_if.sv
// Read/write/clear bus of the wide-read block memory.
interface bram_wide_read_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned RATIO         = 2
);
  logic                          ren;
  logic [ADDRESS_WIDTH-1:0]      raddr;
  logic [RATIO*DATA_WIDTH-1:0]   dout;
  logic                          dout_valid;
  logic                          wen;
  logic [ADDRESS_WIDTH-1:0]      waddr;
  logic [DATA_WIDTH-1:0]         din;
  logic                          clear;
  logic                          busy;

  modport master (
    output ren, raddr, wen, waddr, din, clear,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  ren, raddr, wen, waddr, din, clear,
    output dout, dout_valid, busy
  );
endinterface

// File: rtl/bram_read_pipe.sv
// Data+valid delay line; data registers hold while no valid passes through.
module bram_read_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ports;
    assign unused_ports = clock ^ reset;
    assign out_valid    = in_valid;
    assign out_data     = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];

    // Shift valid every cycle; advance data only alongside a valid bit.
    always_comb begin
      vld_d = '0;
      for (int s = 0; s < STAGES; s++) dat_d[s] = dat_q[s];
      vld_d[0] = in_valid;
      if (in_valid) dat_d[0] = in_data;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
      end
    end

    // Stage registers; reset flushes in-flight reads.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int s = 0; s < STAGES; s++) dat_q[s] <= dat_d[s];
      end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
  end

endmodule

// File: rtl/bram_wide_read.sv
// Simple-dual-port memory: narrow write, RATIO-word wrapping read, clear engine.
module bram_wide_read
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDRESS_WIDTH  = 11,
  parameter int unsigned RATIO          = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 0,
  parameter string       INIT_FILE      = ""
) (
  input logic             clock,
  input logic             reset,
  bram_wide_read_if.slave bus
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned AW1   = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDRESS_WIDTH;
  localparam int unsigned LANES = (RATIO > MAX_RATIO) ? MAX_RATIO : RATIO;
  localparam int unsigned LAT   = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                  (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  // Image preloading is left to the simulation environment.
  logic unused_init;
  assign unused_init = (INIT_FILE != "");

  logic [W-1:0]             mem [DEPTH];
  state_e                   state_q, state_d;
  logic [AW1-1:0]           cnt_q, cnt_d;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [W-1:0]             mem_wdata;
  logic                     rd_accept;
  logic [ADDRESS_WIDTH-1:0] lane_a;
  logic [RATIO*W-1:0]       rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;

  // Clear sequencer; owns the write port while sweeping and gates user traffic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.waddr;
    mem_wdata = bus.din;
    rd_accept = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we    = bus.wen;
        rd_accept = bus.ren;
        if (bus.clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDRESS_WIDTH-1:0];
        mem_wdata = '0;
        if (bus.clear) begin
          cnt_d = '0;
        end else if (cnt_q == AW1'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW1'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gather RATIO consecutive words; optionally forward a same-cycle write.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_accept;
    lane_a   = '0;
    if (rd_accept) begin
      rdata_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_a = ADDRESS_WIDTH'(lane_addr(32'(bus.raddr), i, ADDRESS_WIDTH));
        if ((WRITE_FIRST != 0) && mem_we && (mem_waddr == lane_a))
          rdata_d[i*W +: W] = mem_wdata;
        else
          rdata_d[i*W +: W] = mem[lane_a];
      end
    end
  end

  // FSM, clear counter and first read stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  bram_read_pipe #(
    .WIDTH  (RATIO * W),
    .STAGES (LAT - 1)
  ) u_read_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rvalid_q),
    .in_data   (rdata_q),
    .out_valid (bus.dout_valid),
    .out_data  (bus.dout)
  );

  assign bus.busy = (state_q == CLEAR);

endmodule

// File: tb/tb_bram_wide_read.sv
// Bench: two configurations (WF=0/LAT=1/COR=0 and WF=1/LAT=3/COR=1) on shared stimulus.
module tb_bram_wide_read;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ren = 1'b0, wen = 1'b0, clear = 1'b0;
  logic [3:0] raddr = '0, waddr = '0;
  logic [7:0] din = '0;

  always #5 clock = ~clock;

  bram_wide_read_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RATIO(2)) bif0 ();
  bram_wide_read_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RATIO(2)) bif1 ();

  assign bif0.ren = ren;  assign bif0.raddr = raddr; assign bif0.wen = wen;
  assign bif0.waddr = waddr; assign bif0.din = din; assign bif0.clear = clear;
  assign bif1.ren = ren;  assign bif1.raddr = raddr; assign bif1.wen = wen;
  assign bif1.waddr = waddr; assign bif1.din = din; assign bif1.clear = clear;

  bram_wide_read #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RATIO(2), .READ_LATENCY(1),
                   .WRITE_FIRST(0), .CLEAR_ON_RESET(0), .INIT_FILE("")) dut0 (
    .clock(clock), .reset(reset), .bus(bif0.slave));

  bram_wide_read #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RATIO(2), .READ_LATENCY(3),
                   .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .INIT_FILE("")) dut1 (
    .clock(clock), .reset(reset), .bus(bif1.slave));

  logic [15:0] act_dout  [2];
  logic        act_valid [2];
  logic        act_busy  [2];
  assign act_dout[0] = bif0.dout;  assign act_valid[0] = bif0.dout_valid; assign act_busy[0] = bif0.busy;
  assign act_dout[1] = bif1.dout;  assign act_valid[1] = bif1.dout_valid; assign act_busy[1] = bif1.busy;

  // Reference model: word array, sweep progress, and reads scheduled by due cycle.
  logic [7:0]  mem_m   [2][16];
  bit          sweep   [2];
  int          sidx    [2];
  bit          due_v   [2][8];
  logic [15:0] due_d   [2][8];
  bit          exp_valid [2];
  logic [15:0] exp_dout  [2];
  bit          exp_busy  [2];
  int          cyc;
  int          checks, passes;

  function automatic int lat_of(int d);   return (d == 0) ? 1 : 3; endfunction
  function automatic bit wf_of(int d);    return d == 1;             endfunction
  function automatic bit cor_of(int d);   return d == 1;             endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sweep[d] = cor_of(d);
      sidx[d]  = 0;
      for (int s = 0; s < 8; s++) due_v[d][s] = 1'b0;
      exp_valid[d] = 1'b0;
      exp_dout[d]  = 16'h0000;
      exp_busy[d]  = cor_of(d);
    end
  endtask

  always @(posedge clock) begin : model
    logic [15:0] rd;
    logic [7:0]  w;
    int          a, slot;
    if (!reset) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (sweep[d]) begin
          mem_m[d][sidx[d]] = 8'h00;
          if (clear) sidx[d] = 0;
          else       sidx[d] = sidx[d] + 1;
          if (sidx[d] == 16) sweep[d] = 1'b0;
        end else begin
          if (ren) begin
            rd = 16'h0000;
            for (int i = 0; i < 2; i++) begin
              a = (int'(raddr) + i) % 16;
              w = (wf_of(d) && wen && int'(waddr) == a) ? din : mem_m[d][a];
              rd = rd | (16'(w) << (8 * i));
            end
            slot = (cyc + lat_of(d) - 1) % 8;
            due_v[d][slot] = 1'b1;
            due_d[d][slot] = rd;
          end
          if (wen) mem_m[d][waddr] = din;
          if (clear) begin sweep[d] = 1'b1; sidx[d] = 0; end
        end
        slot = cyc % 8;
        if (due_v[d][slot]) begin
          exp_valid[d] = 1'b1;
          exp_dout[d]  = due_d[d][slot];
          due_v[d][slot] = 1'b0;
        end else begin
          exp_valid[d] = 1'b0;
        end
        exp_busy[d] = sweep[d];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic r, input logic [3:0] ra, input logic w,
                       input logic [3:0] wa, input logic [7:0] wd, input logic c);
    ren = r; raddr = ra; wen = w; waddr = wa; din = wd; clear = c;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    drive(0, 0, 0, 0, 0, 0);
    while ((act_busy[0] || act_busy[1]) && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) $display("FAIL %s idle_timeout: busy0=%b busy1=%b after %0d cycles", tag, act_busy[0], act_busy[1], n);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (act_dout[d] !== 16'h0000) $display("FAIL reset_dout dut%0d: got %h expected 0000", d, act_dout[d]); else passes++;
      checks++; if (act_valid[d] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b expected 0", d, act_valid[d]); else passes++;
      checks++; if (act_busy[d] !== cor_of(d)) $display("FAIL reset_busy dut%0d: got %b expected %b", d, act_busy[d], cor_of(d)); else passes++;
    end
    reset = 1'b0;
    wait_idle("reset_sweep");
    drive(0, 0, 0, 0, 0, 1); tick();
    wait_idle("init_clear");
  endtask

  task automatic test_basic_read();
    drive(0, 0, 1, 3, 8'h11, 0); tick();
    drive(0, 0, 1, 4, 8'h22, 0); tick();
    drive(1, 3, 0, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL basic_valid dut%0d k%0d: got %b expected %b", d, k, act_valid[d], exp_valid[d]); else passes++;
        checks++; if (act_dout[d] !== exp_dout[d]) $display("FAIL basic_dout dut%0d k%0d: got %h expected %h", d, k, act_dout[d], exp_dout[d]); else passes++;
      end
      if (k == 1) begin
        checks++; if (act_valid[0] !== 1'b1 || act_dout[0] !== 16'h2211) $display("FAIL basic_const dut0: got %b/%h expected 1/2211", act_valid[0], act_dout[0]); else passes++;
      end
      if (k == 3) begin
        checks++; if (act_valid[1] !== 1'b1 || act_dout[1] !== 16'h2211) $display("FAIL basic_const dut1: got %b/%h expected 1/2211", act_valid[1], act_dout[1]); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 15, 8'hAA, 0); tick();
    drive(0, 0, 1, 0, 8'h55, 0);  tick();
    drive(1, 15, 0, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL wrap_valid dut%0d k%0d: got %b expected %b", d, k, act_valid[d], exp_valid[d]); else passes++;
        checks++; if (act_dout[d] !== exp_dout[d]) $display("FAIL wrap_dout dut%0d k%0d: got %h expected %h", d, k, act_dout[d], exp_dout[d]); else passes++;
      end
      if (k == 1) begin
        checks++; if (act_dout[0] !== 16'h55AA) $display("FAIL wrap_const dut0: got %h expected 55aa", act_dout[0]); else passes++;
      end
      if (k == 3) begin
        checks++; if (act_dout[1] !== 16'h55AA) $display("FAIL wrap_const dut1: got %h expected 55aa", act_dout[1]); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_collision();
    logic [7:0] want0, want1;
    drive(0, 0, 1, 5, 8'h10, 0); tick();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) drive(1, 5, 1, 5, 8'h77, 0);
      else           drive(1, 5, 0, 0, 0, 0);
      want0 = (pass == 0) ? 8'h10 : 8'h77;
      want1 = 8'h77;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
        for (int d = 0; d < 2; d++) begin
          checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL coll_valid dut%0d p%0d k%0d: got %b expected %b", d, pass, k, act_valid[d], exp_valid[d]); else passes++;
          checks++; if (act_dout[d] !== exp_dout[d]) $display("FAIL coll_dout dut%0d p%0d k%0d: got %h expected %h", d, pass, k, act_dout[d], exp_dout[d]); else passes++;
        end
        if (k == 1) begin
          checks++; if (act_dout[0][7:0] !== want0) $display("FAIL coll_lane0 dut0 p%0d: got %h expected %h", pass, act_dout[0][7:0], want0); else passes++;
        end
        if (k == 3) begin
          checks++; if (act_dout[1][7:0] !== want1) $display("FAIL coll_lane0 dut1 p%0d: got %h expected %h", pass, act_dout[1][7:0], want1); else passes++;
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      drive(k < 3, 4'(k), 0, 0, 0, 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL b2b_valid dut%0d k%0d: got %b expected %b", d, k, act_valid[d], exp_valid[d]); else passes++;
        checks++; if (act_dout[d] !== exp_dout[d]) $display("FAIL b2b_dout dut%0d k%0d: got %h expected %h", d, k, act_dout[d], exp_dout[d]); else passes++;
      end
      checks++; if (act_valid[1] !== (k >= 2 && k <= 4)) $display("FAIL b2b_window dut1 k%0d: got %b expected %b", k, act_valid[1], (k >= 2 && k <= 4)); else passes++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    int n = 0;
    for (int a = 0; a < 16; a++) begin drive(0, 0, 1, 4'(a), 8'hFF, 0); tick(); end
    drive(0, 0, 0, 0, 0, 1); tick();
    while (act_busy[0] && n < 40) begin
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== 1'b0 || exp_valid[d] !== 1'b0) $display("FAIL clear_novalid dut%0d n%0d: got %b model %b expected 0", d, n, act_valid[d], exp_valid[d]); else passes++;
        checks++; if (act_busy[d] !== exp_busy[d]) $display("FAIL clear_busy dut%0d n%0d: got %b expected %b", d, n, act_busy[d], exp_busy[d]); else passes++;
      end
      drive(n < 3, 4'(n), 1, 2, 8'h33, 0);
      n++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (n !== 16) $display("FAIL clear_len dut0: got %0d cycles expected 16", n); else passes++;
    wait_idle("clear_done");
    for (int a = 0; a < 19; a++) begin
      drive(a < 16, 4'(a), 0, 0, 0, 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL clear_rd_valid dut%0d a%0d: got %b expected %b", d, a, act_valid[d], exp_valid[d]); else passes++;
        if (act_valid[d]) begin
          checks++; if (act_dout[d] !== 16'h0000 || exp_dout[d] !== 16'h0000) $display("FAIL clear_rd_zero dut%0d a%0d: got %h model %h expected 0000", d, a, act_dout[d], exp_dout[d]); else passes++;
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), ($urandom_range(0, 49) == 0));
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (act_valid[d] !== exp_valid[d]) $display("FAIL rand_valid dut%0d k%0d: got %b expected %b", d, k, act_valid[d], exp_valid[d]); else passes++;
        checks++; if (act_dout[d] !== exp_dout[d]) $display("FAIL rand_dout dut%0d k%0d: got %h expected %h", d, k, act_dout[d], exp_dout[d]); else passes++;
        checks++; if (act_busy[d] !== exp_busy[d]) $display("FAIL rand_busy dut%0d k%0d: got %b expected %b", d, k, act_busy[d], exp_busy[d]); else passes++;
      end
    end
    wait_idle("rand_done");
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    drive(1, 7, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (act_dout[d] !== 16'h0000) $display("FAIL midrst_dout dut%0d: got %h expected 0000", d, act_dout[d]); else passes++;
      checks++; if (act_valid[d] !== 1'b0) $display("FAIL midrst_valid dut%0d: got %b expected 0", d, act_valid[d]); else passes++;
      checks++; if (act_busy[d] !== cor_of(d)) $display("FAIL midrst_busy dut%0d: got %b expected %b", d, act_busy[d], cor_of(d)); else passes++;
    end
    @(negedge clock);
    reset = 1'b0;
    while (act_busy[1] && n < 40) begin
      checks++; if (act_busy[0] !== 1'b0) $display("FAIL midrst_busy0 n%0d: got %b expected 0", n, act_busy[0]); else passes++;
      n++;
      tick();
    end
    checks++; if (n !== 16) $display("FAIL midrst_sweep_len dut1: got %0d cycles expected 16", n); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    cyc    = 0;
    test_reset();
    test_basic_read();
    test_wrap();
    test_collision();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

endmodule
